position_datapath: RTL

POSITION_DATAPATH -- requirements
Module: position_datapath

---
 rtl/position_datapath_if.sv | 39 +++
 rtl/position_datapath.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/position_datapath_if.sv
`default_nettype none
// ============================================================================
//  Module      : position_datapath_if
//  Description : Control-FSM / maze-memory connection bundle for the
//                position datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
interface position_datapath_if;
    logic       restart;
    logic       moveUp;
    logic       moveDown;
    logic       moveLeft;
    logic       moveRight;
    logic       doneChangePosition;
    logic [8:0] mazeAddr;
    logic       mazeData;
    logic       doneCheckLegal;
    logic       isLegal;
    logic [4:0] cellX;
    logic [3:0] cellY;
    logic [7:0] pixelX;
    logic [6:0] pixelY;
    logic       reachedGoal;

    modport master (
        output restart, moveUp, moveDown, moveLeft, moveRight,
        output doneChangePosition, mazeData,
        input  mazeAddr, doneCheckLegal, isLegal, cellX, cellY,
        input  pixelX, pixelY, reachedGoal
    );

    modport slave (
        input  restart, moveUp, moveDown, moveLeft, moveRight,
        input  doneChangePosition, mazeData,
        output mazeAddr, doneCheckLegal, isLegal, cellX, cellY,
        output pixelX, pixelY, reachedGoal
    );
endinterface
`default_nettype wire

// File: rtl/position_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : position_datapath
//  Description : Player cell tracker; checks one move against the maze wall
//                memory with fixed latency and commits it when legal.
//  Revision    : 1.0 - initial release
// ============================================================================
module position_datapath #(
    parameter int GRID_W  = 20,
    parameter int GRID_H  = 15,
    parameter int CELL    = 8,
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter int GOAL_X  = 19,
    parameter int GOAL_Y  = 14
) (
    input  logic                clock,
    input  logic                reset,
    position_datapath_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_ADDR    = 3'd2,
        S_WAIT    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    localparam logic [4:0] c_start_x = 5'(START_X);
    localparam logic [3:0] c_start_y = 4'(START_Y);
    localparam logic [4:0] c_goal_x  = 5'(GOAL_X);
    localparam logic [3:0] c_goal_y  = 4'(GOAL_Y);
    localparam logic [4:0] c_max_x   = 5'(GRID_W - 1);
    localparam logic [3:0] c_max_y   = 4'(GRID_H - 1);

    state_t     state_q, state_d;
    dir_t       dir_q, dir_d;
    logic [4:0] cell_x_q, cell_x_d;
    logic [3:0] cell_y_q, cell_y_d;
    logic       is_legal_q, is_legal_d;
    logic       done_q, done_d;

    logic [4:0] cand_x;
    logic [3:0] cand_y;
    logic       cand_ok;

    // Candidate is derived from the held cell and direction, so it is stable
    // across ADDR and WAIT and the address can be presented combinationally.
    always_comb begin
        cand_x  = cell_x_q;
        cand_y  = cell_y_q;
        cand_ok = 1'b0;
        case (dir_q)
            DIR_UP: begin
                cand_ok = (cell_y_q != 4'd0);
                cand_y  = cell_y_q - 4'd1;
            end
            DIR_DOWN: begin
                cand_ok = (cell_y_q != c_max_y);
                cand_y  = cell_y_q + 4'd1;
            end
            DIR_LEFT: begin
                cand_ok = (cell_x_q != 5'd0);
                cand_x  = cell_x_q - 5'd1;
            end
            DIR_RIGHT: begin
                cand_ok = (cell_x_q != c_max_x);
                cand_x  = cell_x_q + 5'd1;
            end
            default: cand_ok = 1'b0;
        endcase
        if (!cand_ok) begin
            cand_x = cell_x_q;
            cand_y = cell_y_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        cell_x_d   = cell_x_q;
        cell_y_d   = cell_y_q;
        is_legal_d = is_legal_q;
        if (bus.restart) begin
            state_d    = S_IDLE;
            cell_x_d   = c_start_x;
            cell_y_d   = c_start_y;
            is_legal_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.doneChangePosition) begin
                        state_d = S_CAPTURE;
                        dir_d   = DIR_NONE;
                    end
                end
                S_CAPTURE: begin
                    // Ambiguous (zero or several) key inputs keep the latch.
                    case ({bus.moveUp, bus.moveDown, bus.moveLeft, bus.moveRight})
                        4'b1000: dir_d = DIR_UP;
                        4'b0100: dir_d = DIR_DOWN;
                        4'b0010: dir_d = DIR_LEFT;
                        4'b0001: dir_d = DIR_RIGHT;
                        default: dir_d = dir_q;
                    endcase
                    if (!bus.doneChangePosition) begin
                        state_d = S_ADDR;
                    end
                end
                S_ADDR: state_d = S_WAIT;
                S_WAIT: begin
                    is_legal_d = cand_ok && !bus.mazeData;
                    if (cand_ok && !bus.mazeData) begin
                        cell_x_d = cand_x;
                        cell_y_d = cand_y;
                    end
                    state_d = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            dir_q      <= DIR_NONE;
            cell_x_q   <= c_start_x;
            cell_y_q   <= c_start_y;
            is_legal_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            cell_x_q   <= cell_x_d;
            cell_y_q   <= cell_y_d;
            is_legal_q <= is_legal_d;
            done_q     <= done_d;
        end
    end

    assign bus.mazeAddr       = 9'(int'(cand_y) * GRID_W + int'(cand_x));
    assign bus.doneCheckLegal = done_q;
    assign bus.isLegal        = is_legal_q;
    assign bus.cellX          = cell_x_q;
    assign bus.cellY          = cell_y_q;
    assign bus.pixelX         = 8'(int'(cell_x_q) * CELL);
    assign bus.pixelY         = 7'(int'(cell_y_q) * CELL);
    assign bus.reachedGoal    = (cell_x_q == c_goal_x) && (cell_y_q == c_goal_y);

endmodule
`default_nettype wire
